// File: rtl/spi_slave_shift.sv
// spi_slave_shift: SPI responder shifting CHAR_LEN-bit characters between mosi/miso and a parallel host port.
// All pins are oversampled in clk_in; sclk high and low times must each be at least 4 clk_in periods.
module spi_slave_shift #(
   parameter int CHAR_LEN = 8,
   parameter int CNT_W    = 5
) (
   input  logic                clk_in,
   input  logic                rst,
   input  logic                sclk,
   input  logic                ss_n,
   input  logic                mosi,
   output logic                miso,
   output logic                miso_oe,
   input  logic                cpol,
   input  logic                cpha,
   input  logic                lsb,
   input  logic [CHAR_LEN-1:0] tx_data,
   input  logic                tx_load,
   output logic                tx_empty,
   output logic [CHAR_LEN-1:0] rx_data,
   output logic                rx_valid,
   output logic                underrun,
   output logic                busy
);
   localparam logic [0:0] IDLE = 1'b0, ACTIVE = 1'b1;
   logic [0:0] state;
   logic [2:0] sclk_s;
   logic [1:0] ss_s, mosi_s;
   logic m_cpol, m_cpha, m_lsb;
   logic [CHAR_LEN-1:0] sr, tx_buf, sr_shift, reload_val;
   logic [CNT_W-1:0] cnt;
   logic rise, fall, lead, trail, start, stop, sample, launch, done, reload, first_bit;

   assign rise = sclk_s[1] & ~sclk_s[2];
   assign fall = ~sclk_s[1] & sclk_s[2];
   assign lead = m_cpol ? fall : rise;
   assign trail = m_cpol ? rise : fall;
   assign start = (state == IDLE) & ~ss_s[1];
   assign stop = (state == ACTIVE) & ss_s[1];
   assign sample = (state == ACTIVE) & ~ss_s[1] & (m_cpha ? trail : lead);
   assign launch = (state == ACTIVE) & ~ss_s[1] & (m_cpha ? lead : trail);
   assign done = sample & (cnt == CNT_W'(CHAR_LEN - 1));
   assign reload = start | done;
   assign sr_shift = m_lsb ? {mosi_s[1], sr[CHAR_LEN-1:1]} : {sr[CHAR_LEN-2:0], mosi_s[1]};
   // A load coinciding with a reload goes straight into the shift register
   assign reload_val = tx_load ? tx_data : (tx_empty ? '0 : tx_buf);
   assign first_bit = (start ? lsb : m_lsb) ? reload_val[0] : reload_val[CHAR_LEN-1];
   assign miso_oe = (state == ACTIVE);
   assign busy = (state == ACTIVE);

   always_ff @(posedge clk_in or negedge rst) begin
      if (!rst) begin
         sclk_s <= '0;
         ss_s <= '1;
         mosi_s <= '0;
         state <= IDLE;
         m_cpol <= 1'b0;
         m_cpha <= 1'b0;
         m_lsb <= 1'b0;
         sr <= '0;
         tx_buf <= '0;
         tx_empty <= 1'b1;
         cnt <= '0;
         miso <= 1'b0;
         rx_data <= '0;
         rx_valid <= 1'b0;
         underrun <= 1'b0;
      end else begin
         sclk_s <= {sclk_s[1:0], sclk};
         ss_s <= {ss_s[0], ss_n};
         mosi_s <= {mosi_s[0], mosi};
         rx_valid <= 1'b0;
         if (reload) tx_empty <= 1'b1;
         else if (tx_load) begin
            tx_buf <= tx_data;
            tx_empty <= 1'b0;
         end
         if (reload & ~tx_load & tx_empty) underrun <= 1'b1;
         if (start) begin
            state <= ACTIVE;
            m_cpol <= cpol;
            m_cpha <= cpha;
            m_lsb <= lsb;
            cnt <= '0;
            sr <= reload_val;
            miso <= first_bit;
         end else if (stop) begin
            state <= IDLE;
            cnt <= '0;
            miso <= 1'b0;
         end else if (done) begin
            cnt <= '0;
            rx_data <= sr_shift;
            rx_valid <= 1'b1;
            sr <= reload_val;
            if (!m_cpha) miso <= first_bit;
         end else if (sample) begin
            cnt <= cnt + CNT_W'(1);
            sr <= sr_shift;
         end else if (launch) miso <= m_lsb ? sr[0] : sr[CHAR_LEN-1];
      end
   end
endmodule

// File: tb/tb_spi_slave_shift.sv
// tb_spi_slave_shift: directed SPI master frames; received characters checked by a scoreboard monitor.
module tb_spi_slave_shift;
   logic clk_in = 1'b0;
   logic rst = 1'b0, sclk = 1'b0, ss_n = 1'b1, mosi = 1'b0;
   logic cpol = 1'b0, cpha = 1'b0, lsb = 1'b0, tx_load = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic miso, miso_oe, tx_empty, rx_valid, underrun, busy;
   logic [7:0] rx_data;
   logic [7:0] txq[$], sb[$];
   logic [7:0] mo[4], em[4];
   int errors = 0, checks = 0;

   always #5 clk_in = ~clk_in;

   spi_slave_shift dut (
      .clk_in(clk_in), .rst(rst), .sclk(sclk), .ss_n(ss_n), .mosi(mosi),
      .miso(miso), .miso_oe(miso_oe), .cpol(cpol), .cpha(cpha), .lsb(lsb),
      .tx_data(tx_data), .tx_load(tx_load), .tx_empty(tx_empty), .rx_data(rx_data),
      .rx_valid(rx_valid), .underrun(underrun), .busy(busy)
   );

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endfunction

   task automatic hw(input int h);
      repeat (h) @(negedge clk_in);
   endtask

   // Host side: refill the TX buffer from txq whenever it is empty
   initial forever begin
      @(negedge clk_in);
      tx_load = 1'b0;
      if (rst && tx_empty && txq.size() > 0) begin
         tx_data = txq.pop_front();
         tx_load = 1'b1;
      end
   end

   initial forever begin
      @(negedge clk_in);
      if (rst && rx_valid) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rx_unexpected: got %0h expected none", rx_data);
         end else chk("rx_data", rx_data, sb.pop_front());
      end
   end

   initial begin
      repeat (50000) @(negedge clk_in);
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   task automatic frame(input logic cp, input logic ch, input logic lb, input int nch, input int nbits, input int h);
      logic [7:0] got;
      int b;
      cpol = cp; cpha = ch; lsb = lb; sclk = cp; mosi = 1'b0;
      repeat (6) @(negedge clk_in);
      ss_n = 1'b0;
      repeat (8) @(negedge clk_in);
      chk("miso_oe_on", miso_oe, 1);
      chk("busy_on", busy, 1);
      for (int c = 0; c < nch; c++) begin
         got = '0;
         if (nbits == 8) sb.push_back(mo[c]);
         for (int i = 0; i < nbits; i++) begin
            b = lb ? i : 7 - i;
            if (!ch) begin
               mosi = mo[c][b]; hw(h); got[b] = miso; sclk = ~cp; hw(h); sclk = cp;
            end else begin
               sclk = ~cp; mosi = mo[c][b]; hw(h); got[b] = miso; sclk = cp; hw(h);
            end
         end
         if (nbits == 8) chk("miso_char", got, em[c]);
      end
      hw(h);
      ss_n = 1'b1;
      repeat (4) @(negedge clk_in);
      chk("miso_oe_off", miso_oe, 0);
      chk("busy_off", busy, 0);
      chk("miso_off", miso, 0);
      repeat (4) @(negedge clk_in);
      chk("rx_pending", sb.size(), 0);
   endtask

   initial begin
      repeat (3) @(negedge clk_in);
      chk("rst_miso", miso, 0);
      chk("rst_miso_oe", miso_oe, 0);
      chk("rst_tx_empty", tx_empty, 1);
      chk("rst_rx_data", rx_data, 0);
      chk("rst_rx_valid", rx_valid, 0);
      chk("rst_underrun", underrun, 0);
      chk("rst_busy", busy, 0);
      rst = 1'b1;
      repeat (3) @(negedge clk_in);
      // mode 0, MSB first
      txq.push_back(8'hA5); txq.push_back(8'h00);
      mo[0] = 8'h3C; em[0] = 8'hA5;
      frame(1'b0, 1'b0, 1'b0, 1, 8, 4);
      // mode 3, LSB first
      txq.push_back(8'h81); txq.push_back(8'h00);
      mo[0] = 8'h7E; em[0] = 8'h81;
      frame(1'b1, 1'b1, 1'b1, 1, 8, 6);
      // mode 1, three back-to-back characters
      txq.push_back(8'h11); txq.push_back(8'h22); txq.push_back(8'h33); txq.push_back(8'h00);
      mo[0] = 8'hC3; mo[1] = 8'h5A; mo[2] = 8'h96;
      em[0] = 8'h11; em[1] = 8'h22; em[2] = 8'h33;
      frame(1'b0, 1'b1, 1'b0, 3, 8, 4);
      // mode 2, LSB first, three characters
      txq.push_back(8'h11); txq.push_back(8'h22); txq.push_back(8'h33); txq.push_back(8'h00);
      mo[0] = 8'h0F; mo[1] = 8'hF0; mo[2] = 8'h69;
      frame(1'b1, 1'b0, 1'b1, 3, 8, 4);
      chk("underrun_clear", underrun, 0);
      // frame started with empty TX buffer
      mo[0] = 8'h55; em[0] = 8'h00;
      frame(1'b0, 1'b0, 1'b0, 1, 8, 6);
      chk("underrun_set", underrun, 1);
      chk("tx_empty_after_underrun", tx_empty, 1);
      // abort after 5 bits; the buffered 0x77 must survive
      txq.push_back(8'h96); txq.push_back(8'h77);
      mo[0] = 8'hE7;
      frame(1'b0, 1'b0, 1'b0, 1, 5, 6);
      chk("tx_retained", tx_empty, 0);
      txq.push_back(8'h00);
      mo[0] = 8'hA6; em[0] = 8'h77;
      frame(1'b0, 1'b0, 1'b0, 1, 8, 6);
      chk("underrun_sticky", underrun, 1);
      chk("rx_data_held", rx_data, 8'hA6);
      // asynchronous reset in the middle of a frame
      cpol = 1'b0; cpha = 1'b0; lsb = 1'b0; sclk = 1'b0;
      ss_n = 1'b0;
      repeat (8) @(negedge clk_in);
      sclk = 1'b1; hw(4); sclk = 1'b0; hw(4);
      chk("busy_mid", busy, 1);
      #3 rst = 1'b0;
      #1;
      chk("arst_miso", miso, 0);
      chk("arst_miso_oe", miso_oe, 0);
      chk("arst_tx_empty", tx_empty, 1);
      chk("arst_rx_data", rx_data, 0);
      chk("arst_rx_valid", rx_valid, 0);
      chk("arst_underrun", underrun, 0);
      chk("arst_busy", busy, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
